// File: rtl/arbitro_round_robin_pkg.sv
// Shared definitions for the five-way round-robin arbiter of the filter core.
package arbitro_round_robin_pkg;

  localparam int unsigned N_SOLICITANTES = 5;
  localparam int unsigned ANCHO_CONT     = 8;

  localparam logic [N_SOLICITANTES-1:0] PUNTERO_RESET = 5'b00001;

  typedef enum logic [1:0] {
    LIBRE     = 2'b00,
    EVALUA    = 2'b01,
    CONCEDIDO = 2'b10
  } estado_t;

endpackage

// File: rtl/arbitro_round_robin_shift_bits_left.sv
// One-position rotate left of the priority token (index 0 -> 1 -> ... -> 4 -> 0).
module shift_bits_left
  import arbitro_round_robin_pkg::*;
(
  input  logic [N_SOLICITANTES-1:0] entrada,
  output logic [N_SOLICITANTES-1:0] salida
);

  assign salida = {entrada[N_SOLICITANTES-2:0], entrada[N_SOLICITANTES-1]};

endmodule

// File: rtl/arbitro_round_robin.sv
// Round-robin arbiter sharing one filter datapath between five requesters.
// A one-hot token scans one position per cycle; the grant is held until the
// holder finishes, withdraws its request, or reaches the maximum tenure.
module arbitro_round_robin
  import arbitro_round_robin_pkg::*;
#(
  parameter int unsigned TIEMPO_MAX = 16
)
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SOLICITANTES-1:0] solicitud,
  input  logic                      fin,
  output logic [N_SOLICITANTES-1:0] concesion,
  output logic                      ocupado,
  output logic                      expiro,
  output logic [N_SOLICITANTES-1:0] puntero
);

  // Last count value of a tenure; reaching it on an edge revokes the grant.
  localparam logic [ANCHO_CONT-1:0] LIMITE = ANCHO_CONT'(TIEMPO_MAX - 1);

  estado_t                   estado;
  logic [ANCHO_CONT-1:0]     cont;
  logic [N_SOLICITANTES-1:0] puntero_rot;
  logic                      sigue_pidiendo;
  logic                      liberar;

  shift_bits_left u_rotl (
    .entrada (puntero),
    .salida  (puntero_rot)
  );

  // The holder's own request bit; other requesters are ignored during tenure.
  assign sigue_pidiendo = |(solicitud & concesion);
  assign liberar        = fin || !sigue_pidiendo || (cont == LIMITE);

  // Arbitration FSM with token, tenure counter and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= LIBRE;
      puntero   <= PUNTERO_RESET;
      cont      <= '0;
      concesion <= '0;
      ocupado   <= 1'b0;
      expiro    <= 1'b0;
    end else begin
      expiro <= 1'b0;
      case (estado)
        LIBRE: begin
          concesion <= '0;
          ocupado   <= 1'b0;
          if (|solicitud) estado <= EVALUA;
        end
        EVALUA: begin
          if (solicitud == '0) begin
            estado <= LIBRE;
          end else if (|(solicitud & puntero)) begin
            concesion <= puntero;
            ocupado   <= 1'b1;
            cont      <= '0;
            estado    <= CONCEDIDO;
          end else begin
            puntero <= puntero_rot;
          end
        end
        CONCEDIDO: begin
          cont <= cont + 1'b1;
          if (liberar) begin
            concesion <= '0;
            ocupado   <= 1'b0;
            puntero   <= puntero_rot;
            estado    <= LIBRE;
            // Only a pure timeout is flagged; fin or withdrawal take precedence.
            expiro    <= !fin && sigue_pidiendo;
          end
        end
        default: begin
          estado    <= LIBRE;
          concesion <= '0;
          ocupado   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/arbitro_round_robin.md
# arbitro_round_robin

Round-robin arbiter that shares one filter datapath between five requesters. A one-hot priority token is rotated left to pick the next requester. The grant is held until the holder signals completion, withdraws its request, or exceeds a maximum tenure. The block sits between the requesting channel controllers and the shared filter core. `concesion` drives the core's input-select mux directly.

## Interface
Parameters:
- `TIEMPO_MAX`, default 16: maximum tenure in clock cycles. Legal range is 2–255.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `solicitud`, input, 5: request per requester. Level-sensitive; each bit stays high until the requester is served.
- `fin`, input, 1: the current holder has finished. Sampled only in CONCEDIDO.
- `concesion`, output, 5: one-hot grant, or all zero. Registered.
- `ocupado`, output, 1: high while in CONCEDIDO. Registered.
- `expiro`, output, 1: one-cycle pulse when a grant is revoked by timeout. Registered.
- `puntero`, output, 5: current priority token (one-hot). Exported for debug.

## Operation
- State register with three states: LIBRE, EVALUA, CONCEDIDO. Also an 8-bit tenure counter `cont` and a 5-bit one-hot token `puntero`.
- Token advance uses a 5-bit rotate left, so the token moves index 0→1→2→3→4→0.

Reset values:
- state = LIBRE, puntero = 5'b00001, cont = 0.
- concesion = 0, ocupado = 0, expiro = 0.

LIBRE:
- concesion = 0.
- If `|solicitud`, go to EVALUA. Otherwise stay.
- puntero does not change.

EVALUA (scans one position per cycle):
- If `solicitud` = 0 (all requests withdrawn), go to LIBRE. puntero keeps its value.
- Else if `(solicitud & puntero) != 0`:
  - concesion <= puntero, ocupado <= 1, cont <= 0.
  - Go to CONCEDIDO.
- Else puntero <= rotl(puntero) and stay in EVALUA.
- A match always occurs within 5 cycles while any request is held.

CONCEDIDO:
- cont increments by 1 each cycle.
- Release priority, highest first:
  1. `fin` = 1
  2. the granted bit of `solicitud` = 0
  3. cont == TIEMPO_MAX−1, which also sets expiro <= 1
- On release:
  - concesion <= 0, ocupado <= 0.
  - puntero <= rotl(puntero), so the served requester drops to lowest priority.
  - Go to LIBRE.
- `fin` together with timeout on the same edge counts as `fin`: expiro stays 0.
- Changes on non-granted `solicitud` bits are ignored until release.
- expiro is cleared on every edge where it was not just set.
- `fin` outside CONCEDIDO is ignored.

## Timing
- Request latency: `solicitud` bit rises before edge k, and the token is d positions away from it (d = 0..4). concesion goes high after edge k+1+d. Best case is 2 edges, worst case 6.
- Tenure: concesion is high for at most TIEMPO_MAX cycles. On timeout, expiro is high for exactly the cycle after the edge where concesion falls.
- Release costs 2 cycles before the next grant (CONCEDIDO→LIBRE, then LIBRE→EVALUA). Minimum gap between grants with concesion all zero is 2 cycles.
- Reset asserted mid-grant forces every output to its reset value immediately (asynchronous). The first grant after reset is re-evaluated from token 5'b00001.
- At most one bit of concesion is ever set. The token is never zero.

## Structure
- Shared package holds:
  - State encoding: LIBRE=2'b00, EVALUA=2'b01, CONCEDIDO=2'b10.
  - N_SOLICITANTES = 5.
  - PUNTERO_RESET = 5'b00001.
  - ANCHO_CONT = 8.
- One sub-module: `shift_bits_left`, the existing 5-bit rotate-left block, instantiated once to compute rotl(puntero).
- The rest (FSM, counter, grant register) stays inline.

## Test plan
- Reset, then solicitud = 5'b00001 held → concesion = 5'b00001 after 2 edges. fin pulse → concesion = 0 next edge, puntero = 5'b00010.
- puntero = 5'b00001, solicitud = 5'b10000 → concesion = 5'b10000 after 6 edges (4 scan steps). No other grant bit is ever set.
- solicitud = 5'b11111 held, fin pulsed each grant → grants follow 00001, 00010, 00100, 01000, 10000, 00001 with a 2-cycle gap between grants.
- TIEMPO_MAX = 16, request held, fin never asserted → concesion high for exactly 16 cycles, then expiro pulses 1 cycle and the token advances.
- fin and timeout on the same edge → release with expiro = 0. Request withdrawn mid-tenure → release next edge, expiro = 0.
- rst_n driven low mid-grant → concesion, ocupado, expiro = 0 without a clock edge, and puntero = 5'b00001.
